// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared state type, synchroniser depth, RX FIFO depth and width helper for the SPI responder
package spi_slave_pkg;
  typedef enum logic {IDLE, ACTIVE} state_t;
  localparam int SYNC_STAGES = 2;
  localparam int RX_FIFO_DEPTH = 4;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: 2-FF synchroniser with a third registered copy for edge detection
// Ports: i_clk/i_rst_n (async active-low), i_d async input, o_q synchronised level,
//        o_rise/o_fall one-cycle edge strobes (stage 2 vs delayed copy).
module spi_slave_sync
  import spi_slave_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES:0] r_s;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_s <= {(SYNC_STAGES + 1){RST_VAL}};
    else r_s <= {r_s[SYNC_STAGES-1:0], i_d};
  assign o_q    = r_s[SYNC_STAGES-1];
  assign o_rise = o_q & ~r_s[SYNC_STAGES];
  assign o_fall = ~o_q & r_s[SYNC_STAGES];
endmodule

// File: rtl/spi_slave_responder.sv
// spi_slave_responder: oversampled SPI responder with valid/ready TX and RX word streams
// Ports: io_systemClock/io_systemReset (async active-low); io_spi_sclk/mosi/ss/miso/miso_oe SPI pins;
//        io_tx_valid/ready/payload TX stream; io_rx_valid/ready/payload RX stream;
//        io_busy selected flag; io_overrun/io_underrun one-cycle status pulses.
// Build option: define SPI_SLAVE_RX_FIFO_EN to replace the RX holding register with a 4-entry FIFO.
module spi_slave_responder
  import spi_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter logic CPOL = 1'b0,
  parameter logic CPHA = 1'b0,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX = {DATA_WIDTH{1'b1}}
) (
  input  logic                  io_systemClock,
  input  logic                  io_systemReset,
  input  logic                  io_spi_sclk,
  input  logic                  io_spi_mosi,
  input  logic                  io_spi_ss,
  output logic                  io_spi_miso,
  output logic                  io_spi_miso_oe,
  input  logic                  io_tx_valid,
  output logic                  io_tx_ready,
  input  logic [DATA_WIDTH-1:0] io_tx_payload,
  output logic                  io_rx_valid,
  input  logic                  io_rx_ready,
  output logic [DATA_WIDTH-1:0] io_rx_payload,
  output logic                  io_busy,
  output logic                  io_overrun,
  output logic                  io_underrun
);
  localparam int CW = clog2(DATA_WIDTH + 1);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_tx, r_rx, w_load_word, w_rx_word;
  logic r_miso;
  logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall, w_mosi;
  logic w_sclk_lvl_unused, w_ss_lvl_unused;
  logic [1:0] w_mosi_edge_unused;
  logic w_active, w_sel, w_lead, w_trail, w_sample, w_shift, w_done, w_load;

  spi_slave_sync #(.RST_VAL(CPOL)) u_sclk (
    .i_clk(io_systemClock), .i_rst_n(io_systemReset), .i_d(io_spi_sclk),
    .o_q(w_sclk_lvl_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
  spi_slave_sync #(.RST_VAL(1'b0)) u_mosi (
    .i_clk(io_systemClock), .i_rst_n(io_systemReset), .i_d(io_spi_mosi),
    .o_q(w_mosi), .o_rise(w_mosi_edge_unused[1]), .o_fall(w_mosi_edge_unused[0]));
  spi_slave_sync #(.RST_VAL(1'b1)) u_ss (
    .i_clk(io_systemClock), .i_rst_n(io_systemReset), .i_d(io_spi_ss),
    .o_q(w_ss_lvl_unused), .o_rise(w_ss_rise), .o_fall(w_ss_fall));

  assign w_active    = r_state == ACTIVE;
  assign w_sel       = (r_state == IDLE) & w_ss_fall;
  assign w_lead      = CPOL ? w_sclk_fall : w_sclk_rise;
  assign w_trail     = CPOL ? w_sclk_rise : w_sclk_fall;
  // Edges are only honoured while ACTIVE, so an edge in the select cycle is ignored.
  assign w_sample    = w_active & (CPHA ? w_trail : w_lead);
  assign w_shift     = w_active & (CPHA ? w_lead : w_trail);
  assign w_done      = w_sample & (r_cnt == CW'(DATA_WIDTH - 1));
  // No reload when the word ends in the deselect cycle: the next word would never be sent.
  assign w_load      = w_sel | (w_done & ~w_ss_rise);
  assign w_load_word = io_tx_valid ? io_tx_payload : DEFAULT_TX;
  assign w_rx_word   = {r_rx[DATA_WIDTH-2:0], w_mosi};
  assign io_tx_ready = w_load & io_tx_valid;
  assign io_underrun = w_load & ~io_tx_valid;
  assign io_busy     = w_active;
  assign io_spi_miso_oe = w_active;
  assign io_spi_miso = r_miso;

  always_ff @(posedge io_systemClock or negedge io_systemReset)
    if (!io_systemReset) r_state <= IDLE;
    else r_state <= w_next;

  always_comb
    w_next = w_sel ? ACTIVE : (w_active & w_ss_rise) ? IDLE : r_state;

  // A shift edge with the counter at 0 follows a (re)load: drive the MSB without shifting.
  always_ff @(posedge io_systemClock or negedge io_systemReset)
    if (!io_systemReset) begin
      r_cnt  <= '0;
      r_tx   <= '0;
      r_rx   <= '0;
      r_miso <= 1'b0;
    end else begin
      if (w_sample) begin
        r_rx  <= w_rx_word;
        r_cnt <= w_done ? '0 : r_cnt + 1'b1;
      end
      if (w_shift) begin
        if (r_cnt == '0) r_miso <= r_tx[DATA_WIDTH-1];
        else begin
          r_tx   <= r_tx << 1;
          r_miso <= r_tx[DATA_WIDTH-2];
        end
      end
      if (w_load) begin
        r_tx <= w_load_word;
        if (!CPHA) r_miso <= w_load_word[DATA_WIDTH-1];
      end
      if (w_active & w_ss_rise) begin
        r_cnt  <= '0;
        r_miso <= 1'b0;
      end
    end

`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int AW = clog2(RX_FIFO_DEPTH);
  localparam int FW = clog2(RX_FIFO_DEPTH + 1);
  logic [DATA_WIDTH-1:0] r_fifo [RX_FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [FW-1:0] r_fcnt;
  logic w_full, w_pop, w_push;
  assign w_full        = r_fcnt == FW'(RX_FIFO_DEPTH);
  assign w_pop         = (r_fcnt != '0) & io_rx_ready;
  assign w_push        = w_done & (~w_full | w_pop);
  assign io_rx_valid   = r_fcnt != '0;
  assign io_rx_payload = r_fifo[r_rp];
  assign io_overrun    = w_done & w_full & ~w_pop;
  always_ff @(posedge io_systemClock or negedge io_systemReset)
    if (!io_systemReset) begin
      r_fifo <= '{default: '0};
      r_wp   <= '0;
      r_rp   <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wp] <= w_rx_word;
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_fcnt <= r_fcnt + FW'(w_push) - FW'(w_pop);
    end
`else
  logic r_rx_valid;
  logic [DATA_WIDTH-1:0] r_rx_hold;
  logic w_accept;
  // A word completing while the held word drains replaces it and keeps valid high.
  assign w_accept      = w_done & (~r_rx_valid | io_rx_ready);
  assign io_rx_valid   = r_rx_valid;
  assign io_rx_payload = r_rx_hold;
  assign io_overrun    = w_done & r_rx_valid & ~io_rx_ready;
  always_ff @(posedge io_systemClock or negedge io_systemReset)
    if (!io_systemReset) begin
      r_rx_valid <= 1'b0;
      r_rx_hold  <= '0;
    end else if (w_accept) begin
      r_rx_valid <= 1'b1;
      r_rx_hold  <= w_rx_word;
    end else if (r_rx_valid & io_rx_ready) r_rx_valid <= 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave_responder.sv
// tb_spi_slave_responder: directed bench for a mode-0 and a mode-3 responder instance
module tb_spi_slave_responder;
`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam bit FIFO = 1'b1;
`else
  localparam bit FIFO = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] sclk, mosi, ss, txv, rxr;
  logic [1:0] miso, oe, txr, rxv, busy, ovr, und;
  logic [7:0] txp [2];
  logic [7:0] rxp [2];
  int vectors = 0;
  int miscompares = 0;
  int n_txr [2];
  int n_und [2];
  int n_ovr [2];

  always #5 clk = ~clk;

  spi_slave_responder u0 (
    .io_systemClock(clk), .io_systemReset(rst_n),
    .io_spi_sclk(sclk[0]), .io_spi_mosi(mosi[0]), .io_spi_ss(ss[0]),
    .io_spi_miso(miso[0]), .io_spi_miso_oe(oe[0]),
    .io_tx_valid(txv[0]), .io_tx_ready(txr[0]), .io_tx_payload(txp[0]),
    .io_rx_valid(rxv[0]), .io_rx_ready(rxr[0]), .io_rx_payload(rxp[0]),
    .io_busy(busy[0]), .io_overrun(ovr[0]), .io_underrun(und[0]));

  spi_slave_responder #(.CPOL(1'b1), .CPHA(1'b1)) u3 (
    .io_systemClock(clk), .io_systemReset(rst_n),
    .io_spi_sclk(sclk[1]), .io_spi_mosi(mosi[1]), .io_spi_ss(ss[1]),
    .io_spi_miso(miso[1]), .io_spi_miso_oe(oe[1]),
    .io_tx_valid(txv[1]), .io_tx_ready(txr[1]), .io_tx_payload(txp[1]),
    .io_rx_valid(rxv[1]), .io_rx_ready(rxr[1]), .io_rx_payload(rxp[1]),
    .io_busy(busy[1]), .io_overrun(ovr[1]), .io_underrun(und[1]));

  always @(negedge clk)
    for (int k = 0; k < 2; k++) begin
      n_txr[k] <= n_txr[k] + int'(txr[k]);
      n_und[k] <= n_und[k] + int'(und[k]);
      n_ovr[k] <= n_ovr[k] + int'(ovr[k]);
    end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  task automatic sel(input int m);
    ss[m] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic desel(input int m);
    ss[m] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic pop(input int m);
    rxr[m] = 1'b1;
    @(negedge clk);
    rxr[m] = 1'b0;
    @(negedge clk);
  endtask

  // Controller side: m=0 is mode 0, m=1 is mode 3; sends nb bits MSB-first, reads MISO.
  task automatic xfer(input int m, input logic [7:0] d, input int nb, output logic [7:0] rd);
    rd = '0;
    for (int i = 7; i > 7 - nb; i--) begin
      if (m == 0) begin
        mosi[m] = d[i];
        half();
        rd[i] = miso[m];
        sclk[m] = 1'b1;
        half();
        sclk[m] = 1'b0;
      end else begin
        sclk[m] = 1'b0;
        mosi[m] = d[i];
        half();
        rd[i] = miso[m];
        sclk[m] = 1'b1;
        half();
      end
    end
    half();
  endtask

  initial begin
    logic [7:0] rd;
    int bt, bu, bo;
    rst_n = 1'b0;
    sclk = 2'b10;
    ss = 2'b11;
    mosi = 2'b00;
    txv = 2'b11;
    rxr = 2'b00;
    txp[0] = 8'hA5;
    txp[1] = 8'hC3;
    repeat (3) @(negedge clk);
    chk("reset_u0", {1'b0, miso[0], oe[0], txr[0], rxv[0], busy[0], ovr[0], und[0], rxp[0]}, 16'h0);
    chk("reset_u3", {1'b0, miso[1], oe[1], txr[1], rxv[1], busy[1], ovr[1], und[1], rxp[1]}, 16'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    bt = n_txr[0];
    bu = n_und[0];
    sel(0);
    txv[0] = 1'b0;
    xfer(0, 8'h3C, 8, rd);
    chk("m0_miso_word", 16'(rd), 16'h00A5);
    chk("m0_rx_valid", 16'(rxv[0]), 16'h1);
    chk("m0_rx_payload", 16'(rxp[0]), 16'h003C);
    desel(0);
    chk("m0_tx_ready_count", 16'(n_txr[0] - bt), 16'h1);
    chk("m0_reload_underrun", 16'(n_und[0] - bu), 16'h1);
    pop(0);
    chk("m0_rx_valid_after_pop", 16'(rxv[0]), 16'h0);

    bt = n_txr[1];
    bu = n_und[1];
    sel(1);
    txp[1] = 8'h5A;
    xfer(1, 8'h12, 8, rd);
    chk("m3_miso_word1", 16'(rd), 16'h00C3);
    chk("m3_rx_word1", 16'(rxp[1]), 16'h0012);
    chk("m3_rx_valid1", 16'(rxv[1]), 16'h1);
    pop(1);
    txv[1] = 1'b0;
    xfer(1, 8'h34, 8, rd);
    chk("m3_miso_word2", 16'(rd), 16'h005A);
    chk("m3_rx_word2", 16'(rxp[1]), 16'h0034);
    desel(1);
    chk("m3_tx_ready_count", 16'(n_txr[1] - bt), 16'h2);
    chk("m3_underrun_count", 16'(n_und[1] - bu), 16'h1);

    rxr[0] = 1'b1;
    bt = n_txr[0];
    bu = n_und[0];
    sel(0);
    txp[0] = 8'h55;
    txv[0] = 1'b1;
    xfer(0, 8'h00, 8, rd);
    txv[0] = 1'b0;
    desel(0);
    chk("underrun_miso_word", 16'(rd), 16'h00FF);
    chk("underrun_count", 16'(n_und[0] - bu), 16'h1);
    chk("underrun_tx_ready_count", 16'(n_txr[0] - bt), 16'h1);
    chk("underrun_rx_drained", 16'(rxv[0]), 16'h0);
    rxr[0] = 1'b0;

    bo = n_ovr[0];
    sel(0);
    xfer(0, 8'h01, 8, rd);
    chk("ovr_first_word", 16'(rxp[0]), 16'h0001);
    xfer(0, 8'h02, 8, rd);
    chk("ovr_held_word", 16'(rxp[0]), 16'h0001);
    chk("ovr_rx_valid", 16'(rxv[0]), 16'h1);
    desel(0);
    chk("ovr_count", 16'(n_ovr[0] - bo), FIFO ? 16'h0 : 16'h1);
    pop(0);
    chk("ovr_valid_after_pop1", 16'(rxv[0]), FIFO ? 16'h1 : 16'h0);
    chk("ovr_payload_after_pop1", 16'(rxp[0]), FIFO ? 16'h0002 : 16'h0001);
    pop(0);
    chk("ovr_valid_after_pop2", 16'(rxv[0]), 16'h0);

    sel(0);
    xfer(0, 8'hF0, 5, rd);
    ss[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_miso_oe", 16'(oe[0]), 16'h0);
    chk("abort_busy", 16'(busy[0]), 16'h0);
    chk("abort_miso", 16'(miso[0]), 16'h0);
    repeat (5) @(negedge clk);
    chk("abort_no_rx_valid", 16'(rxv[0]), 16'h0);
    txp[0] = 8'h69;
    txv[0] = 1'b1;
    sel(0);
    txv[0] = 1'b0;
    xfer(0, 8'h96, 8, rd);
    chk("after_abort_miso", 16'(rd), 16'h0069);
    chk("after_abort_rx_valid", 16'(rxv[0]), 16'h1);
    chk("after_abort_rx_payload", 16'(rxp[0]), 16'h0096);
    desel(0);

    txp[0] = 8'h33;
    txv[0] = 1'b1;
    sel(0);
    txv[0] = 1'b0;
    xfer(0, 8'hAA, 4, rd);
    chk("midword_active", 16'({oe[0], busy[0], rxv[0]}), 16'h7);
    #2 rst_n = 1'b0;
    #1 chk("midword_reset_u0", {1'b0, miso[0], oe[0], txr[0], rxv[0], busy[0], ovr[0], und[0], rxp[0]}, 16'h0);
    ss[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    txp[0] = 8'h7E;
    txv[0] = 1'b1;
    sel(0);
    txv[0] = 1'b0;
    xfer(0, 8'h81, 8, rd);
    chk("post_reset_miso", 16'(rd), 16'h007E);
    chk("post_reset_rx_valid", 16'(rxv[0]), 16'h1);
    chk("post_reset_rx_payload", 16'(rxp[0]), 16'h0081);
    desel(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
